mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-request memory access sequencer: byte/word loads and stores plus word-block COPY.
// Load/store respond 2 cycles after accept, COPY 2*len+1 (1 if len=0), illegal op 1; response held until rsp_ready.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_addr,
    input  logic [3:0]  req_addr2,
    input  logic [3:0]  req_len,
    input  logic [8:0]  req_wbyte,
    input  logic [15:0] req_wword,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [8:0]  rsp_byte,
    output logic [15:0] rsp_word,
    output logic        rsp_err,
    output logic        busy,
    output logic [3:0]  mem_addr,
    output logic [8:0]  mem_wbyte,
    output logic [15:0] mem_wword,
    output logic [1:0]  mem_w,
    input  logic [8:0]  mem_byte,
    input  logic [15:0] mem_word
);

    localparam logic [2:0] OP_LB   = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SB   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_COPY = 3'b100;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, RD, WR, CPY_RD, CPY_WR, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [3:0]  addr_q, addr2_q, len_q, idx_q, idx_inc;
    logic [8:0]  wbyte_q;
    logic [15:0] wword_q, buf_q;
    logic [1:0]  mem_w_raw;
    logic        accept;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign idx_inc   = idx_q + 4'd1;

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_w_raw = MW_NONE;
        mem_w     = MW_NONE;
        mem_wbyte = '0;
        mem_wword = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_LB, OP_LW: state_nxt = RD;
                        OP_SB, OP_SW: state_nxt = WR;
                        OP_COPY:      state_nxt = (req_len != 4'd0) ? CPY_RD : RESP;
                        default:      state_nxt = RESP;
                    endcase
                end
            end
            RD: begin
                mem_addr  = addr_q;
                state_nxt = RESP;
            end
            WR: begin
                mem_addr  = addr_q;
                mem_w_raw = (op_q == OP_SB) ? MW_BYTE : MW_WORD;
                state_nxt = RESP;
            end
            CPY_RD: begin
                mem_addr  = addr_q + idx_q;
                state_nxt = CPY_WR;
            end
            CPY_WR: begin
                mem_addr  = addr2_q + idx_q;
                mem_w_raw = MW_WORD;
                state_nxt = (idx_inc < len_q) ? CPY_RD : RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset gates the write strobe so an in-flight copy cannot write on the reset edge.
        mem_w = rst ? MW_NONE : mem_w_raw;
        if (mem_w == MW_BYTE) mem_wbyte = wbyte_q;
        if (mem_w == MW_WORD) mem_wword = (state == CPY_WR) ? buf_q : wword_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            addr2_q  <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            wbyte_q  <= '0;
            wword_q  <= '0;
            buf_q    <= '0;
            rsp_byte <= '0;
            rsp_word <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= req_op;
                        addr_q   <= req_addr;
                        addr2_q  <= req_addr2;
                        len_q    <= req_len;
                        wbyte_q  <= req_wbyte;
                        wword_q  <= req_wword;
                        idx_q    <= '0;
                        rsp_byte <= '0;
                        rsp_word <= '0;
                        rsp_err  <= (req_op > OP_COPY);
                    end
                end
                RD: begin
                    if (op_q == OP_LB) rsp_byte <= mem_byte;
                    else               rsp_word <= mem_word;
                end
                CPY_RD: buf_q <= mem_word;
                CPY_WR: idx_q <= idx_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural memory, vector table, scoreboard and corner sequences.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [3:0]  req_addr, req_addr2, req_len;
    logic [8:0]  req_wbyte;
    logic [15:0] req_wword;
    logic        rsp_valid, rsp_ready;
    logic [8:0]  rsp_byte;
    logic [15:0] rsp_word;
    logic        rsp_err, busy;
    logic [3:0]  mem_addr;
    logic [8:0]  mem_wbyte;
    logic [15:0] mem_wword;
    logic [1:0]  mem_w;
    logic [8:0]  mem_byte;
    logic [15:0] mem_word;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_addr2(req_addr2), .req_len(req_len),
        .req_wbyte(req_wbyte), .req_wword(req_wword),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_byte(rsp_byte),
        .rsp_word(rsp_word), .rsp_err(rsp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_wbyte(mem_wbyte), .mem_wword(mem_wword),
        .mem_w(mem_w), .mem_byte(mem_byte), .mem_word(mem_word)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on rising edge.
    logic [8:0]  bmem [16];
    logic [15:0] wmem [16];
    logic        preload = 1'b1;
    int          nbw = 0, nww = 0, viol = 0;

    assign mem_byte = bmem[mem_addr];
    assign mem_word = wmem[mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 16; k++) begin
                bmem[k] <= 9'(9'h0F0 + k);
                wmem[k] <= 16'(16'h1111 * k);
            end
        end else if (mem_w == 2'b01) begin
            bmem[mem_addr] <= mem_wbyte;
            nbw <= nbw + 1;
        end else if (mem_w == 2'b10) begin
            wmem[mem_addr] <= mem_wword;
            nww <= nww + 1;
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (mem_w == 2'b11) viol++;
        if (mem_w != 2'b01 && mem_wbyte != 9'd0) viol++;
        if (mem_w != 2'b10 && mem_wword != 16'd0) viol++;
        if (rst && mem_w != 2'b00) viol++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0]  b;
        logic [15:0] w;
        logic        e;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  a, a2, len;
        logic [8:0]  wb;
        logic [15:0] ww;
        logic [8:0]  eb;
        logic [15:0] ew;
        logic        ee;
        int          lat, nb, nw;
    } vec_t;

    task automatic start_req(input logic [2:0] op, input logic [3:0] a, input logic [3:0] a2,
                             input logic [3:0] len, input logic [8:0] wb, input logic [15:0] ww);
        int t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_addr2 = a2;
        req_len = len; req_wbyte = wb; req_wword = ww;
        @(posedge clk);
    endtask

    task automatic do_req(input vec_t v, input int hold);
        int   lat, b0, w0;
        exp_t ex;
        logic [15:0] sw;
        logic [8:0]  sb;
        b0 = nbw; w0 = nww;
        rsp_ready = (hold == 0);
        start_req(v.op, v.a, v.a2, v.len, v.wb, v.ww);
        sbq.push_back('{b: v.eb, w: v.ew, e: v.ee, lat: v.lat});
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ex = sbq.pop_front();
        check("rsp_latency", 32'(lat), 32'(ex.lat));
        check("rsp_byte", 32'(rsp_byte), 32'(ex.b));
        check("rsp_word", 32'(rsp_word), 32'(ex.w));
        check("rsp_err", 32'(rsp_err), 32'(ex.e));
        sw = rsp_word; sb = rsp_byte;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_word", 32'(rsp_word), 32'(sw));
            check("hold_rsp_byte", 32'(rsp_byte), 32'(sb));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_return", 32'(req_ready), 32'd1);
        check("byte_writes", 32'(nbw - b0), 32'(v.nb));
        check("word_writes", 32'(nww - w0), 32'(v.nw));
    endtask

    vec_t vt[12];

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = '0; req_addr = '0; req_addr2 = '0; req_len = '0; req_wbyte = '0; req_wword = '0;
        vt[0]  = '{3'b011, 4'd3,  4'd0, 4'd0, 9'h0,   16'hBEEF, 9'h0,   16'h0,    1'b0, 2, 0, 1};
        vt[1]  = '{3'b001, 4'd3,  4'd0, 4'd0, 9'h0,   16'h0,    9'h0,   16'hBEEF, 1'b0, 2, 0, 0};
        vt[2]  = '{3'b010, 4'd15, 4'd0, 4'd0, 9'h1A5, 16'h0,    9'h0,   16'h0,    1'b0, 2, 1, 0};
        vt[3]  = '{3'b000, 4'd15, 4'd0, 4'd0, 9'h0,   16'h0,    9'h1A5, 16'h0,    1'b0, 2, 0, 0};
        vt[4]  = '{3'b111, 4'd5,  4'd6, 4'd3, 9'h55,  16'h5555, 9'h0,   16'h0,    1'b1, 1, 0, 0};
        vt[5]  = '{3'b101, 4'd1,  4'd2, 4'd1, 9'h0,   16'h0,    9'h0,   16'h0,    1'b1, 1, 0, 0};
        vt[6]  = '{3'b100, 4'd1,  4'd2, 4'd0, 9'h0,   16'h0,    9'h0,   16'h0,    1'b0, 1, 0, 0};
        vt[7]  = '{3'b001, 4'd7,  4'd0, 4'd0, 9'h0,   16'h0,    9'h0,   16'h7777, 1'b0, 2, 0, 0};
        vt[8]  = '{3'b000, 4'd2,  4'd0, 4'd0, 9'h0,   16'h0,    9'h0F2, 16'h0,    1'b0, 2, 0, 0};
        vt[9]  = '{3'b011, 4'd15, 4'd0, 4'd0, 9'h0,   16'h1234, 9'h0,   16'h0,    1'b0, 2, 0, 1};
        vt[10] = '{3'b001, 4'd15, 4'd0, 4'd0, 9'h0,   16'h0,    9'h0,   16'h1234, 1'b0, 2, 0, 0};
        vt[11] = '{3'b000, 4'd3,  4'd0, 4'd0, 9'h0,   16'h0,    9'h0F3, 16'h0,    1'b0, 2, 0, 0};

        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_mem_w", 32'(mem_w), 32'd0);
        check("reset_rsp_word", 32'(rsp_word), 32'd0);
        preload = 1'b0;
        rst = 1'b0;
        #1;
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) do_req(vt[i], 0);

        // Source range wraps 15 -> 0.
        do_req('{3'b011, 4'd0, 4'd0, 4'd0, 9'h0, 16'hCAFE, 9'h0, 16'h0, 1'b0, 2, 0, 1}, 0);
        do_req('{3'b100, 4'd14, 4'd4, 4'd3, 9'h0, 16'h0, 9'h0, 16'h0, 1'b0, 7, 0, 3}, 0);
        check("copy_dst4", 32'(wmem[4]), 32'h0000EEEE);
        check("copy_dst5", 32'(wmem[5]), 32'h00001234);
        check("copy_dst6", 32'(wmem[6]), 32'h0000CAFE);
        check("copy_dst7_untouched", 32'(wmem[7]), 32'h00007777);

        // Response backpressure.
        do_req('{3'b001, 4'd4, 4'd0, 4'd0, 9'h0, 16'h0, 9'h0, 16'hEEEE, 1'b0, 2, 0, 0}, 5);

        // Reset during the second write of a 4-word copy.
        begin
            int w0;
            w0 = nww;
            start_req(3'b100, 4'd8, 4'd12, 4'd4, 9'h0, 16'h0);
            @(negedge clk);
            req_valid = 1'b0;
            repeat (3) @(negedge clk);
            check("midcopy_busy", 32'(busy), 32'd1);
            check("midcopy_mem_w_pre", 32'(mem_w), 32'd2);
            rst = 1'b1;
            #1;
            check("midcopy_mem_w_rst", 32'(mem_w), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("after_rst_busy", 32'(busy), 32'd0);
            check("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("after_rst_req_ready", 32'(req_ready), 32'd1);
            check("partial_copy_writes", 32'(nww - w0), 32'd1);
            check("partial_copy_dst12", 32'(wmem[12]), 32'h00008888);
            check("partial_copy_dst13", 32'(wmem[13]), 32'h0000DDDD);
        end

        // Controller still healthy after the aborted copy.
        do_req('{3'b001, 4'd12, 4'd0, 4'd0, 9'h0, 16'h0, 9'h0, 16'h8888, 1'b0, 2, 0, 0}, 0);

        check("mem_protocol_violations", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
